// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: FSM state
// encodings, parity type codes and the parity helper.
package uart_tx_fifo_drain_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  localparam logic ParEven = 1'b0;
  localparam logic ParOdd  = 1'b1;

  // Turns the XOR reduction of the data word into the transmitted parity bit.
  function automatic logic apply_par_type(input logic xor_red, input logic typ);
    return xor_red ^ (typ == ParOdd);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_bit_timer.sv
// Bit-period timer: restarts on load with the latched prescale (0 means 1)
// and pulses bit_done on the last cycle of every bit while running.
module uart_tx_fifo_drain_bit_timer #(
  parameter int unsigned PrescW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
  input  logic [PrescW-1:0] prescale,
  output logic              bit_done
);

  logic [PrescW-1:0] period_q;
  logic [PrescW-1:0] cnt_q;

  assign bit_done = (cnt_q == period_q - PrescW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= PrescW'(1);
      cnt_q    <= '0;
    end else if (load) begin
      period_q <= (prescale == '0) ? PrescW'(1) : prescale;
      cnt_q    <= '0;
    end else if (run) begin
      cnt_q <= bit_done ? '0 : cnt_q + PrescW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Read-domain FIFO consumer: pops a word whenever the FIFO is non-empty and
// sends it as a UART frame (start, data LSB first, optional parity, stop).
module uart_tx_fifo_drain
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned PrescW    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] rd_data,
  input  logic                 empty,
  output logic                 r_inc,
  input  logic [PrescW-1:0]    prescale,
  input  logic                 par_en,
  input  logic                 par_typ,
  output logic                 tx_out,
  output logic                 busy
);

  localparam int unsigned IdxW = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  state_e                 state_q;
  logic [DataWidth-1:0]   shreg_q;
  logic [IdxW-1:0]        bit_idx_q;
  logic                   par_en_q;
  logic                   par_bit_q;
  logic                   tx_q;
  logic                   busy_q;
  logic                   r_inc_q;
  logic                   bit_done;
  logic                   load_evt;

  // A new word is taken from idle, or straight out of the last stop cycle.
  assign load_evt = !empty && ((state_q == StIdle) || ((state_q == StStop) && bit_done));

  uart_tx_fifo_drain_bit_timer #(
    .PrescW(PrescW)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_evt),
    .run      (busy_q),
    .prescale (prescale),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      r_inc_q   <= 1'b0;
    end else begin
      r_inc_q <= 1'b0;
      if (load_evt) begin
        state_q   <= StStart;
        shreg_q   <= rd_data;
        bit_idx_q <= '0;
        par_en_q  <= par_en;
        par_bit_q <= apply_par_type(^rd_data, par_typ);
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
        r_inc_q   <= 1'b1;
      end else if (bit_done) begin
        case (state_q)
          StStart: begin
            state_q   <= StData;
            bit_idx_q <= '0;
            tx_q      <= shreg_q[0];
            shreg_q   <= shreg_q >> 1;
          end
          StData: begin
            if (bit_idx_q == IdxW'(DataWidth - 1)) begin
              state_q <= par_en_q ? StParity : StStop;
              tx_q    <= par_en_q ? par_bit_q : 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + IdxW'(1);
              tx_q      <= shreg_q[0];
              shreg_q   <= shreg_q >> 1;
            end
          end
          StParity: begin
            state_q <= StStop;
            tx_q    <= 1'b1;
          end
          StStop: begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;
  assign r_inc  = r_inc_q;

endmodule
